dmem_lsu: RTL and testbench

Load/store initiator that drives the data RAM port (ce/we/raddr/waddr/sel/data_i, combinational data_o) on behalf of the MEM stage. It accepts one byte, halfword or word request through a valid/ready handshake. It generates byte-lane selects and replicated store data, sequences the RAM access over a configurable number of cycles, then extracts and sign- or zero-extends load data. It returns a response through a second valid/ready handshake. Little-endian lane mapping.

---
 rtl/dmem_lsu_if.sv | 32 +++
 rtl/dmem_lsu.sv | 200 ++++++++++++++++++++
 tb/tb_dmem_lsu.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
// Request/response handshake bundle between the MEM stage and dmem_lsu.
// master = MEM stage side, slave = load/store unit side.
interface dmem_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] resp_badvaddr;

    modport master (
        output req_valid, req_we, req_size, req_signed,
        output req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata,
        input  resp_err, resp_badvaddr
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed,
        input  req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata,
        output resp_err, resp_badvaddr
    );
endinterface

// File: rtl/dmem_lsu.sv
// Data-RAM load/store initiator: lane select, store replication, load extend.
// Optional DMEM_ALIGN_CHECK_EN: misaligned requests fault instead of aligning.
module dmem_lsu #(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_lsu_if.slave         bus,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [3:0]        ram_sel,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [ADDR_W-1:0] acc_addr;
    logic [3:0]        sel_n;
    logic [31:0]       wdata_n;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       ext;

`ifdef DMEM_ALIGN_CHECK_EN
    logic              misal;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] bva_q, bva_d;

    always_comb begin
        misal = 1'b0;
        unique case (bus.req_size)
            2'd0:    misal = 1'b0;
            2'd1:    misal = bus.req_addr[0];
            default: misal = |bus.req_addr[1:0];
        endcase
    end

    assign acc_addr = bus.req_addr;
`else
    // Low bits are silently dropped so the access lands on a natural boundary.
    always_comb begin
        acc_addr = bus.req_addr;
        unique case (bus.req_size)
            2'd0:    acc_addr = bus.req_addr;
            2'd1:    acc_addr[0] = 1'b0;
            default: acc_addr[1:0] = 2'b00;
        endcase
    end
`endif

    always_comb begin
        sel_n   = 4'b1111;
        wdata_n = bus.req_wdata;
        unique case (bus.req_size)
            2'd0: begin
                sel_n   = 4'b0001 << acc_addr[1:0];
                wdata_n = {4{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                sel_n   = acc_addr[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                sel_n   = 4'b1111;
                wdata_n = bus.req_wdata;
            end
        endcase
    end

    // Little-endian: the addressed lane is shifted down to bit 0.
    assign byte_v = 8'(ram_rdata >> {addr_q[1:0], 3'b000});
    assign half_v = 16'(ram_rdata >> {addr_q[1], 4'b0000});

    always_comb begin
        ext = ram_rdata;
        unique case (size_q)
            2'd0:    ext = {{24{sgn_q & byte_v[7]}}, byte_v};
            2'd1:    ext = {{16{sgn_q & half_v[15]}}, half_v};
            default: ext = ram_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
        err_d   = err_q;
        bva_d   = bva_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = acc_addr;
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    sgn_d   = bus.req_signed;
                    sel_d   = sel_n;
                    wdata_d = wdata_n;
                    rdata_d = '0;
                    cnt_d   = '0;
                    state_d = ACCESS;
`ifdef DMEM_ALIGN_CHECK_EN
                    err_d = misal;
                    bva_d = misal ? bus.req_addr : '0;
                    if (misal) state_d = DONE;
`endif
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = ext;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            sgn_q   <= 1'b0;
            sel_q   <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            bva_q <= '0;
        end else begin
            err_q <= err_d;
            bva_q <= bva_d;
        end
    end

    assign bus.resp_err      = err_q;
    assign bus.resp_badvaddr = bva_q;
`else
    assign bus.resp_err      = 1'b0;
    assign bus.resp_badvaddr = '0;
`endif

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == DONE);
    assign bus.resp_rdata = rdata_q;
    assign ram_ce         = (state_q == ACCESS);
    assign ram_we         = (state_q == ACCESS) & we_q;
    assign ram_raddr      = addr_q;
    assign ram_waddr      = addr_q;
    assign ram_sel        = sel_q;
    assign ram_wdata      = wdata_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: one RD_LAT=1 and one RD_LAT=3 instance,
// each with a small behavioural RAM.
module tb_dmem_lsu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_lsu_if #(.ADDR_W(32)) bus1 ();
    dmem_lsu_if #(.ADDR_W(32)) bus3 ();

    logic        ram1_ce, ram1_we, ram3_ce, ram3_we;
    logic [31:0] ram1_raddr, ram1_waddr, ram3_raddr, ram3_waddr;
    logic [3:0]  ram1_sel, ram3_sel;
    logic [31:0] ram1_wdata, ram1_rdata, ram3_wdata, ram3_rdata;

    dmem_lsu #(.ADDR_W(32), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
        .ram_ce(ram1_ce), .ram_we(ram1_we),
        .ram_raddr(ram1_raddr), .ram_waddr(ram1_waddr),
        .ram_sel(ram1_sel), .ram_wdata(ram1_wdata),
        .ram_rdata(ram1_rdata)
    );

    dmem_lsu #(.ADDR_W(32), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave),
        .ram_ce(ram3_ce), .ram_we(ram3_we),
        .ram_raddr(ram3_raddr), .ram_waddr(ram3_waddr),
        .ram_sel(ram3_sel), .ram_wdata(ram3_wdata),
        .ram_rdata(ram3_rdata)
    );

    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];

    always @(posedge clk) begin
        if (ram1_ce && ram1_we)
            for (int i = 0; i < 4; i++)
                if (ram1_sel[i]) mem1[ram1_waddr[9:2]][8*i +: 8] <= ram1_wdata[8*i +: 8];
    end

    always @(posedge clk) begin
        if (ram3_ce && ram3_we)
            for (int j = 0; j < 4; j++)
                if (ram3_sel[j]) mem3[ram3_waddr[9:2]][8*j +: 8] <= ram3_wdata[8*j +: 8];
    end

    assign ram1_rdata = mem1[ram1_raddr[9:2]];
    assign ram3_rdata = mem3[ram3_raddr[9:2]];

    // Shared stimulus; cur selects which instance is driven and observed.
    logic        cur = 1'b0;
    logic        t_valid = 1'b0, t_rready = 1'b0, t_we = 1'b0, t_sgn = 1'b0;
    logic [1:0]  t_size = 2'd0;
    logic [31:0] t_addr = '0, t_wdata = '0;

    assign bus1.req_valid  = t_valid & ~cur;
    assign bus3.req_valid  = t_valid & cur;
    assign bus1.resp_ready = t_rready & ~cur;
    assign bus3.resp_ready = t_rready & cur;
    assign bus1.req_we     = t_we;
    assign bus3.req_we     = t_we;
    assign bus1.req_size   = t_size;
    assign bus3.req_size   = t_size;
    assign bus1.req_signed = t_sgn;
    assign bus3.req_signed = t_sgn;
    assign bus1.req_addr   = t_addr;
    assign bus3.req_addr   = t_addr;
    assign bus1.req_wdata  = t_wdata;
    assign bus3.req_wdata  = t_wdata;

    logic        s_rdy, s_vld, s_err, s_ce, s_we;
    logic [31:0] s_rdata, s_bva, s_waddr, s_raddr, s_wdata;
    logic [3:0]  s_sel;

    assign s_rdy   = cur ? bus3.req_ready     : bus1.req_ready;
    assign s_vld   = cur ? bus3.resp_valid    : bus1.resp_valid;
    assign s_err   = cur ? bus3.resp_err      : bus1.resp_err;
    assign s_rdata = cur ? bus3.resp_rdata    : bus1.resp_rdata;
    assign s_bva   = cur ? bus3.resp_badvaddr : bus1.resp_badvaddr;
    assign s_ce    = cur ? ram3_ce    : ram1_ce;
    assign s_we    = cur ? ram3_we    : ram1_we;
    assign s_sel   = cur ? ram3_sel   : ram1_sel;
    assign s_waddr = cur ? ram3_waddr : ram1_waddr;
    assign s_raddr = cur ? ram3_raddr : ram1_raddr;
    assign s_wdata = cur ? ram3_wdata : ram1_wdata;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    int          lat, ce_n;
    logic        rdy_bad, stable, g_we;
    logic [3:0]  g_sel;
    logic [31:0] g_waddr, g_raddr, g_wdata, r_rdata, r_bva;
    logic        r_err;

    task automatic txn(input logic inst, input logic we, input logic [1:0] sz,
                       input logic sg, input logic [31:0] ad,
                       input logic [31:0] wd, input int hold);
        int n;
        cur = inst;
        @(negedge clk);
        check("idle_rdy", 32'(s_rdy), 32'd1);
        t_we = we; t_size = sz; t_sgn = sg; t_addr = ad; t_wdata = wd;
        t_valid = 1'b1;
        @(posedge clk);
        #1 t_valid = 1'b0;
        lat = 0; ce_n = 0; rdy_bad = 1'b0; n = 0;
        g_we = 1'b0; g_sel = '0; g_waddr = '0; g_raddr = '0; g_wdata = '0;
        @(negedge clk);
        while (!s_vld && n < 20) begin
            lat++;
            if (s_ce) begin
                ce_n++;
                g_we = s_we; g_sel = s_sel; g_waddr = s_waddr;
                g_raddr = s_raddr; g_wdata = s_wdata;
            end
            if (s_rdy) rdy_bad = 1'b1;
            n++;
            @(negedge clk);
        end
        check("resp_vld", 32'(s_vld), 32'd1);
        r_rdata = s_rdata; r_err = s_err; r_bva = s_bva;
        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!s_vld || s_rdata !== r_rdata || s_rdy) stable = 1'b0;
        end
        if (s_rdy) rdy_bad = 1'b1;
        t_rready = 1'b1;
        @(posedge clk);
        #1 t_rready = 1'b0;
        check("rdy_busy", 32'(rdy_bad), 32'd0);
        check("rdy_after", 32'(s_rdy), 32'd1);
        check("vld_after", 32'(s_vld), 32'd0);
    endtask

    initial begin
        cur = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ce", 32'(ram1_ce), 32'd0);
        check("rst_vld", 32'(bus1.resp_valid), 32'd0);
        check("rst_rdata", bus1.resp_rdata, 32'd0);
        check("rst_err", 32'(bus1.resp_err), 32'd0);
        check("rst_sel", 32'(ram1_sel), 32'd0);
        check("rst_waddr", ram1_waddr, 32'd0);
        check("rst_wdata", ram1_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rdy", 32'(bus1.req_ready), 32'd1);

        // store byte A5 at 0x103
        txn(1'b0, 1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_00A5, 0);
        check("sb_lat", 32'(lat), 32'd1);
        check("sb_ce", 32'(ce_n), 32'd1);
        check("sb_we", 32'(g_we), 32'd1);
        check("sb_sel", 32'(g_sel), 32'h8);
        check("sb_wdata", g_wdata, 32'hA5A5_A5A5);
        check("sb_waddr", g_waddr, 32'h103);
        check("sb_raddr", g_raddr, 32'h103);
        check("sb_rdata", r_rdata, 32'd0);
        check("sb_mem", 32'(mem1[8'h40][31:24]), 32'hA5);

        txn(1'b0, 1'b1, 2'd2, 1'b0, 32'h200, 32'h80FF_1234, 0);
        check("sw_sel", 32'(g_sel), 32'hF);
        check("sw_mem", mem1[8'h80], 32'h80FF_1234);

        txn(1'b0, 1'b0, 2'd0, 1'b1, 32'h203, 32'd0, 0);
        check("lb_203", r_rdata, 32'hFFFF_FF80);
        check("lb_lat", 32'(lat), 32'd1);
        check("lb_ce", 32'(ce_n), 32'd1);
        check("lb_we", 32'(g_we), 32'd0);
        check("lb_sel", 32'(g_sel), 32'h8);
        txn(1'b0, 1'b0, 2'd1, 1'b0, 32'h202, 32'd0, 0);
        check("lhu_202", r_rdata, 32'h0000_80FF);
        check("lhu_sel", 32'(g_sel), 32'hC);
        txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h200, 32'd0, 0);
        check("lw_200", r_rdata, 32'h80FF_1234);
        txn(1'b0, 1'b0, 2'd1, 1'b1, 32'h202, 32'd0, 0);
        check("lh_202", r_rdata, 32'hFFFF_80FF);
        txn(1'b0, 1'b0, 2'd0, 1'b0, 32'h201, 32'd0, 0);
        check("lbu_201", r_rdata, 32'h0000_0012);
        txn(1'b0, 1'b0, 2'd0, 1'b1, 32'h200, 32'd0, 0);
        check("lb_200", r_rdata, 32'h0000_0034);

        // misaligned half store and word load
        txn(1'b0, 1'b1, 2'd1, 1'b0, 32'h101, 32'h0000_BEEF, 0);
`ifdef DMEM_ALIGN_CHECK_EN
        check("mh_ce", 32'(ce_n), 32'd0);
        check("mh_lat", 32'(lat), 32'd0);
        check("mh_err", 32'(r_err), 32'd1);
        check("mh_bva", r_bva, 32'h101);
        check("mh_rdata", r_rdata, 32'd0);
`else
        check("mh_ce", 32'(ce_n), 32'd1);
        check("mh_sel", 32'(g_sel), 32'h3);
        check("mh_waddr", g_waddr, 32'h100);
        check("mh_wdata", g_wdata, 32'hBEEF_BEEF);
        check("mh_err", 32'(r_err), 32'd0);
        check("mh_bva", r_bva, 32'd0);
        check("mh_mem", 32'(mem1[8'h40][15:0]), 32'hBEEF);
`endif
        check("mh_keep", 32'(mem1[8'h40][31:24]), 32'hA5);
        txn(1'b0, 1'b0, 2'd3, 1'b0, 32'h203, 32'd0, 0);
`ifdef DMEM_ALIGN_CHECK_EN
        check("mw_err", 32'(r_err), 32'd1);
        check("mw_bva", r_bva, 32'h203);
        check("mw_rdata", r_rdata, 32'd0);
        check("mw_ce", 32'(ce_n), 32'd0);
`else
        check("mw_err", 32'(r_err), 32'd0);
        check("mw_rdata", r_rdata, 32'h80FF_1234);
        check("mw_raddr", g_raddr, 32'h200);
`endif

        // back-to-back store then load
        txn(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF, 0);
        txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 0);
        check("b2b_load", r_rdata, 32'hDEAD_BEEF);
        check("b2b_err", 32'(r_err), 32'd0);

        // RD_LAT=3 instance with backpressure on the response
        txn(1'b1, 1'b1, 2'd2, 1'b0, 32'h200, 32'h80FF_1234, 0);
        check("l3_slat", 32'(lat), 32'd1);
        txn(1'b1, 1'b0, 2'd0, 1'b1, 32'h203, 32'd0, 5);
        check("l3_lat", 32'(lat), 32'd3);
        check("l3_ce", 32'(ce_n), 32'd3);
        check("l3_rdata", r_rdata, 32'hFFFF_FF80);
        check("l3_stable", 32'(stable), 32'd1);

        // reset during a load access of the RD_LAT=3 instance
        cur = 1'b1;
        txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'd0, 0);
        @(negedge clk);
        t_we = 1'b0; t_size = 2'd2; t_addr = 32'h200; t_valid = 1'b1;
        @(posedge clk);
        #1 t_valid = 1'b0;
        @(negedge clk);
        check("ar_ce_pre", 32'(s_ce), 32'd1);
        #1 rst_n = 1'b0;
        #1 check("ar_ce", 32'(s_ce), 32'd0);
        check("ar_vld", 32'(s_vld), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_rdy", 32'(s_rdy), 32'd1);
        check("ar_mem", mem3[8'h80], 32'h80FF_1234);

        // reset during a store access: no write may land
        txn(1'b0, 1'b1, 2'd2, 1'b0, 32'h104, 32'd0, 0);
        @(negedge clk);
        t_we = 1'b1; t_size = 2'd0; t_addr = 32'h104;
        t_wdata = 32'h0000_00AA; t_valid = 1'b1;
        @(posedge clk);
        #1 t_valid = 1'b0;
        #1 check("as_ce_pre", 32'(s_ce), 32'd1);
        rst_n = 1'b0;
        #1 check("as_ce", 32'(s_ce), 32'd0);
        check("as_we", 32'(s_we), 32'd0);
        check("as_sel", 32'(s_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("as_rdy", 32'(s_rdy), 32'd1);
        check("as_mem", mem1[8'h41], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=done");
        $fatal(1, "watchdog");
    end
endmodule
